// File: rtl/sw_ctrl_arm_sync_if.sv
// Control-word / sync bundle between the PPC control register and the
// arm/sync block. master drives the word and sync; slave returns events.
interface sw_ctrl_arm_sync_if #(
  parameter int SYNC_CNT_W = 32,
  parameter int ARM_CNT_W  = 16
);
  logic [31:0]           user_data_in;
  logic                  sync_in;
  logic                  cnt_rst_pulse;
  logic                  sync_out;
  logic                  armed;
  logic [ARM_CNT_W-1:0]  arm_count;
  logic [SYNC_CNT_W-1:0] sync_count;

  modport master (
    output user_data_in,
    output sync_in,
    input  cnt_rst_pulse,
    input  sync_out,
    input  armed,
    input  arm_count,
    input  sync_count
  );

  modport slave (
    input  user_data_in,
    input  sync_in,
    output cnt_rst_pulse,
    output sync_out,
    output armed,
    output arm_count,
    output sync_count
  );
endinterface

// File: rtl/sw_ctrl_arm_sync.sv
// Turns the software control word into command pulses and an armed,
// delayed sync_out. Ports: user_clk, user_rst_n (sync, active-low), bus.
module sw_ctrl_arm_sync #(
  parameter int SYNC_CNT_W = 32,
  parameter int ARM_CNT_W  = 16
) (
  input  logic                 user_clk,
  input  logic                 user_rst_n,
  sw_ctrl_arm_sync_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DELAY
  } state_t;

  localparam int B_CNT_RST = 0;
  localparam int B_CLR     = 1;
  localparam int B_ARM     = 2;
  localparam int B_FORCE   = 3;
  localparam int B_SYNC    = 4;

  state_t                state_q;
  state_t                state_d;
  logic [4:0]            cur;
  logic [4:0]            prev_q;
  logic [4:0]            rise;
  logic                  arm_fall;
  logic [15:0]           off_q;
  logic [15:0]           off_d;
  logic [15:0]           dcnt_q;
  logic [15:0]           dcnt_d;
  logic                  fire;
  logic                  cnt_rst_q;
  logic                  sync_out_q;
  logic [ARM_CNT_W-1:0]  arm_cnt_q;
  logic [SYNC_CNT_W-1:0] sync_cnt_q;
  logic                  arm_sat;
  logic                  unused_bits;

  assign unused_bits = ^bus.user_data_in[15:4];

  // Sync edge rides along with the command bits so one
  // register and one rise term cover every edge detector.
  assign cur      = {bus.sync_in, bus.user_data_in[3:0]};
  assign rise     = cur & ~prev_q;
  assign arm_fall = prev_q[B_ARM] & ~cur[B_ARM];
  assign arm_sat  = &arm_cnt_q;

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    dcnt_d  = dcnt_q;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A same-edge sync rise is deliberately not taken here.
        if (rise[B_ARM]) begin
          off_d   = bus.user_data_in[31:16];
          state_d = ARMED;
        end
      end
      ARMED: begin
        // Disarm beats a coincident sync edge.
        if (arm_fall) begin
          state_d = IDLE;
        end else if (rise[B_SYNC]) begin
          if (off_q == 16'd0) begin
            fire    = 1'b1;
            state_d = IDLE;
          end else begin
            dcnt_d  = off_q;
            state_d = DELAY;
          end
        end
      end
      DELAY: begin
        // Fires on the edge where the count reads 1, giving
        // exactly D edges between the sync edge and the fire.
        dcnt_d = dcnt_q - 16'd1;
        if (dcnt_q == 16'd1) begin
          fire    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      // Load live inputs so levels held through reset
      // do not look like rises afterwards.
      prev_q     <= cur;
      state_q    <= IDLE;
      off_q      <= '0;
      dcnt_q     <= '0;
      cnt_rst_q  <= 1'b0;
      sync_out_q <= 1'b0;
      arm_cnt_q  <= '0;
      sync_cnt_q <= '0;
    end else begin
      prev_q     <= cur;
      state_q    <= state_d;
      off_q      <= off_d;
      dcnt_q     <= dcnt_d;
      cnt_rst_q  <= rise[B_CNT_RST];
      sync_out_q <= fire | rise[B_FORCE];
      if (rise[B_CLR]) begin
        arm_cnt_q <= '0;
      end else if (fire && !arm_sat) begin
        arm_cnt_q <= arm_cnt_q + ARM_CNT_W'(1);
      end
      if (rise[B_CLR]) begin
        sync_cnt_q <= '0;
      end else if (rise[B_SYNC]) begin
        sync_cnt_q <= sync_cnt_q + SYNC_CNT_W'(1);
      end
    end
  end

  assign bus.cnt_rst_pulse = cnt_rst_q;
  assign bus.sync_out      = sync_out_q;
  assign bus.armed         = (state_q != IDLE);
  assign bus.arm_count     = arm_cnt_q;
  assign bus.sync_count    = sync_cnt_q;

endmodule

// File: tb/tb_sw_ctrl_arm_sync.sv
// Bench for sw_ctrl_arm_sync: directed scenarios plus random traffic,
// all cycles checked against an event-time reference model.
module tb_sw_ctrl_arm_sync;

  localparam int SW = 8;
  localparam int AW = 3;

  logic user_clk = 1'b0;
  logic user_rst_n = 1'b0;

  always #5 user_clk = ~user_clk;

  sw_ctrl_arm_sync_if #(
    .SYNC_CNT_W(SW),
    .ARM_CNT_W(AW)
  ) bus ();

  sw_ctrl_arm_sync #(
    .SYNC_CNT_W(SW),
    .ARM_CNT_W(AW)
  ) dut (
    .user_clk(user_clk),
    .user_rst_n(user_rst_n),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: mode 0 idle, 1 armed, 2 waiting
  // for absolute edge m_target.
  logic [4:0]  m_prev = '0;
  int          m_mode = 0;
  int          m_off = 0;
  longint      m_target = 0;
  longint      ecount = 0;
  int          m_sc = 0;
  int          m_ac = 0;
  logic        m_so = 1'b0;
  logic        m_cp = 1'b0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)",
               tag, got, exp, ecount);
    end
  endtask

  task automatic model_edge();
    logic [4:0] cur;
    logic [4:0] r;
    logic fall2;
    logic fire;
    cur = {bus.sync_in, bus.user_data_in[3:0]};
    if (!user_rst_n) begin
      m_prev = cur;
      m_mode = 0;
      m_off  = 0;
      m_sc   = 0;
      m_ac   = 0;
      m_so   = 1'b0;
      m_cp   = 1'b0;
    end else begin
      r = cur & ~m_prev;
      fall2 = m_prev[2] & ~cur[2];
      fire = 1'b0;
      if (m_mode == 0) begin
        if (r[2]) begin
          m_off  = int'(bus.user_data_in[31:16]);
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (fall2) begin
          m_mode = 0;
        end else if (r[4]) begin
          if (m_off == 0) begin
            fire = 1'b1;
            m_mode = 0;
          end else begin
            m_target = ecount + longint'(m_off);
            m_mode = 2;
          end
        end
      end else begin
        if (ecount == m_target) begin
          fire = 1'b1;
          m_mode = 0;
        end
      end
      m_so = fire | r[3];
      m_cp = r[0];
      if (r[1]) m_sc = 0;
      else if (r[4]) m_sc = (m_sc + 1) % (1 << SW);
      if (r[1]) m_ac = 0;
      else if (fire && m_ac < (1 << AW) - 1) m_ac = m_ac + 1;
      m_prev = cur;
    end
    ecount++;
  endtask

  task automatic tick();
    @(posedge user_clk);
    model_edge();
    #1;
    chk("cnt_rst_pulse", 32'(bus.cnt_rst_pulse), 32'(m_cp));
    chk("sync_out", 32'(bus.sync_out), 32'(m_so));
    chk("armed", 32'(bus.armed), 32'(m_mode != 0));
    chk("arm_count", 32'(bus.arm_count), 32'(m_ac));
    chk("sync_count", 32'(bus.sync_count), 32'(m_sc));
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n;
    int lat;
    logic [31:0] w;

    // Reset with bits 0 and 2 held high, then release.
    bus.user_data_in = 32'h0000_0005;
    bus.sync_in = 1'b0;
    user_rst_n = 1'b0;
    ticks(3);
    user_rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.cnt_rst_pulse) n++;
    end
    chk("rst_release_no_pulse", 32'(n), 32'd0);
    chk("rst_release_idle", 32'(bus.armed), 32'd0);

    // Single cnt_rst pulse one cycle after the write edge.
    bus.user_data_in = 32'h0;
    tick();
    bus.user_data_in = 32'h1;
    tick();
    chk("cnt_rst_first", 32'(bus.cnt_rst_pulse), 32'd1);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.cnt_rst_pulse) n++;
    end
    chk("cnt_rst_width", 32'(n), 32'd0);
    bus.user_data_in = 32'h0;
    tick();

    // D=3 arm: sync_out in the cycle after edge k+3.
    bus.user_data_in = 32'h0003_0004;
    ticks(2);
    chk("d3_armed", 32'(bus.armed), 32'd1);
    bus.sync_in = 1'b1;
    tick();
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.sync_out) begin
        lat = i;
        chk("d3_armed_drop", 32'(bus.armed), 32'd0);
        break;
      end
    end
    chk("d3_latency", 32'(lat), 32'd3);
    chk("d3_arm_count", 32'(bus.arm_count), 32'd1);
    bus.sync_in = 1'b0;
    bus.user_data_in = 32'h0;
    tick();

    // Clear counters, then D=0 with three sync rises.
    bus.user_data_in = 32'h2;
    tick();
    bus.user_data_in = 32'h0;
    tick();
    bus.user_data_in = 32'h0000_0004;
    ticks(2);
    n = 0;
    lat = 0;
    for (int i = 0; i < 3; i++) begin
      bus.sync_in = 1'b1;
      tick();
      if (bus.sync_out) n++;
      if (bus.sync_out && i == 0) lat = 1;
      bus.sync_in = 1'b0;
      tick();
      if (bus.sync_out) n++;
    end
    chk("d0_pulses", 32'(n), 32'd1);
    chk("d0_latency1", 32'(lat), 32'd1);
    chk("d0_sync_count", 32'(bus.sync_count), 32'd3);
    chk("d0_arm_count", 32'(bus.arm_count), 32'd1);
    bus.user_data_in = 32'h0;
    tick();

    // Arm then disarm before any sync: nothing fires.
    bus.user_data_in = 32'h0000_0004;
    ticks(2);
    bus.user_data_in = 32'h0;
    tick();
    bus.sync_in = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.sync_out) n++;
    end
    bus.sync_in = 1'b0;
    chk("disarm_no_fire", 32'(n), 32'd0);
    chk("disarm_idle", 32'(bus.armed), 32'd0);
    chk("disarm_arm_count", 32'(bus.arm_count), 32'd1);
    tick();

    // Clear rise on the same edge as a sync rise.
    bus.user_data_in = 32'h2;
    bus.sync_in = 1'b1;
    tick();
    chk("clr_same_sync", 32'(bus.sync_count), 32'd0);
    chk("clr_same_arm", 32'(bus.arm_count), 32'd0);
    bus.user_data_in = 32'h0;
    bus.sync_in = 1'b0;
    tick();

    // D=10 with a force rise four cycles after the sync.
    bus.user_data_in = 32'h000A_0004;
    ticks(2);
    bus.sync_in = 1'b1;
    tick();
    bus.sync_in = 1'b0;
    n = 0;
    for (int i = 1; i <= 15; i++) begin
      if (i == 4) bus.user_data_in = 32'h000A_000C;
      tick();
      if (bus.sync_out) n++;
    end
    chk("force_two_pulses", 32'(n), 32'd2);
    bus.user_data_in = 32'h0;
    tick();

    // Reset mid-delay aborts the pending fire.
    bus.user_data_in = 32'h000A_0004;
    ticks(2);
    bus.sync_in = 1'b1;
    tick();
    bus.sync_in = 1'b0;
    ticks(2);
    user_rst_n = 1'b0;
    ticks(2);
    user_rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.sync_out) n++;
    end
    chk("rst_abort_no_fire", 32'(n), 32'd0);
    chk("rst_abort_count", 32'(bus.arm_count), 32'd0);
    bus.user_data_in = 32'h0;
    tick();

    // Random traffic: quasi-static word, toggling sync,
    // small offsets, occasional reset.
    for (int c = 0; c < 20000; c++) begin
      if ($urandom_range(0, 1999) == 0) begin
        user_rst_n = 1'b0;
        ticks(int'($urandom_range(1, 3)));
        user_rst_n = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) bus.sync_in = ~bus.sync_in;
      if ($urandom_range(0, 19) == 0) begin
        w = bus.user_data_in;
        case ($urandom_range(0, 9))
          0: w[0] = ~w[0];
          1: w[1] = ~w[1];
          2, 3: w[3] = ~w[3];
          default: w[2] = ~w[2];
        endcase
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 7) == 0)
            w[31:16] = 16'($urandom_range(0, 60));
          else
            w[31:16] = 16'($urandom_range(0, 6));
        end
        w[15:4] = 12'($urandom);
        bus.user_data_in = w;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
